cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Execute-stage controller directly downstream of cpu_core.
- Consumes the instruction register (ir), one-hot micro-step vector (clks) and sequencer state from cpu_core.
- Owns four 8-bit general registers and Z/C flags; executes ALU/move ops over one or two micro-steps.
- Drives the sequencing feedback cpu_core consumes: end_inst, jmp_inst, hlt_inst, inst_condition, jmp_address.

Parameters:
- STEPS, 16, width of clks one-hot micro-step vector; must match cpu_core.
- EXEC_STATE, 2'b01, value of state during which the unit acts; all other states are inert.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all internal state.
- ir  input  32  current instruction: [31:24] opcode, [17:16] rd, [9:8] rs, [7:0] imm/address.
- clks  input  STEPS  one-hot micro-step; clks[0] = first execute step.
- state  input  2  cpu_core sequencer state.
- inst_condition  output  1  1 = current instruction's jump condition is true.
- end_inst  output  1  last micro-step of current instruction.
- jmp_inst  output  1  current instruction is a jump type.
- hlt_inst  output  1  halt request.
- jmp_address  output  8  jump target = ir[7:0].
- regs  output  32  {R3,R2,R1,R0}, debug/observe.
- flags  output  2  {C,Z}.

Behaviour:
- Reset (async, any time): R0..R3 = 0, Z = 0, C = 0, internal temp = 0. Outputs go to the idle values below immediately.
- Gating: act = (state == EXEC_STATE).
  - If act = 0: end_inst, jmp_inst, hlt_inst = 0; inst_condition = 0; no register writes.
- jmp_address = ir[7:0] always (combinational).
- Control outputs are combinational from ir, clks, state, flags and regs.
- Register/flag writes occur on the rising clk while act is high and the named clks bit is set.
- Opcodes:
  - 0x00 NOP: end_inst at clks[0]; no writes.
  - 0x01 MOVI: at clks[0], Rd <= imm; end_inst; flags unchanged.
  - 0x02 MOV: at clks[0], Rd <= Rs; end_inst; flags unchanged.
  - 0x03 ADD: two steps.
    - clks[0]: temp <= {carry, Rd + Rs} (9-bit sum).
    - clks[1]: Rd <= temp[7:0]; C <= temp[8]; Z <= (temp[7:0] == 0); end_inst.
  - 0x04 SUB: as ADD with Rd - Rs.
    - C = borrow (1 when Rs > Rd unsigned); result wraps mod 256.
  - 0x05 JMP: at clks[0]: jmp_inst = 1, inst_condition = 1, end_inst = 1.
  - 0x06 JZ: at clks[0]: jmp_inst = 1, inst_condition = Z, end_inst = 1.
  - 0x07 JC: as JZ with inst_condition = C.
  - 0x08 DJNZ: two steps; Z/C unchanged.
    - clks[0]: Rd <= Rd - 1 (0 wraps to 0xFF).
    - clks[1]: jmp_inst = 1, inst_condition = (Rd != 0) using the decremented value, end_inst = 1.
  - 0xFF HLT: at clks[0]: hlt_inst = 1, end_inst = 1.
  - Undefined opcodes: behave exactly as NOP.
- Conditions are evaluated from current flag values at the evaluating step. A flag write and a jump never share a step, so there is no same-edge hazard.
- Rd == Rs is legal:
  - ADD doubles Rd.
  - SUB yields 0 with Z = 1, C = 0.
  - MOV is a no-op.
- clks bits beyond an opcode's last step: no writes, all control outputs 0. This covers a stalled core that keeps clocking.
- If clks is not one-hot (0 or multiple bits), only the lowest set bit is honoured; all-zero means no action.
- Reset mid-instruction (e.g. between ADD steps):
  - temp is cleared; the partial result is lost.
  - After reset, a clks[1] without a prior clks[0] writes temp = 0: Rd = 0, Z = 1, C = 0.
  - This case is defined, not an error.

Test Plan:
- Reset then MOVI R2,0x5A at clks[0] in EXEC_STATE -> end_inst = 1 that step; next edge regs = 0x005A0000; flags = 00.
- R0 = 0xF0, R1 = 0x20, ADD R0,R1 -> clks[0]: end_inst = 0; after clks[1]: R0 = 0x10, C = 1, Z = 0, end_inst = 1 during clks[1]. Then SUB R0,R0 -> R0 = 0, Z = 1, C = 0.
- Z = 1, JZ 0x3C -> jmp_inst = 1, inst_condition = 1, jmp_address = 0x3C, end_inst = 1. With Z = 0 -> inst_condition = 0.
- R3 = 2, DJNZ R3,0x10 twice -> first: R3 = 1, inst_condition = 1. Second: R3 = 0, inst_condition = 0. A third from R3 = 0 -> R3 = 0xFF, inst_condition = 1.
- HLT with state = EXEC_STATE -> hlt_inst = 1, end_inst = 1. Same ir with state = 2'b00 -> all control outputs 0; regs unchanged.
- Assert reset between ADD clks[0] and clks[1] (R0 = 0x05, R1 = 0x03) -> regs/flags cleared asynchronously. Subsequent clks[1] -> R0 = 0, Z = 1, C = 0.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Execute-stage controller: owns R0..R3 and Z/C, runs one- or two-step ops keyed by the clks one-hot step.
// Control outputs are combinational in the current step; no backpressure, cpu_core paces it through state/clks.
module cpu_control_unit #(
    parameter int         STEPS      = 16,
    parameter logic [1:0] EXEC_STATE = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir,
    input  logic [STEPS-1:0] clks,
    input  logic [1:0]       state,
    output logic             inst_condition,
    output logic             end_inst,
    output logic             jmp_inst,
    output logic             hlt_inst,
    output logic [7:0]       jmp_address,
    output logic [31:0]      regs,
    output logic [1:0]       flags
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOVI = 8'h01;
    localparam logic [7:0] OP_MOV  = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h03;
    localparam logic [7:0] OP_SUB  = 8'h04;
    localparam logic [7:0] OP_JMP  = 8'h05;
    localparam logic [7:0] OP_JZ   = 8'h06;
    localparam logic [7:0] OP_JC   = 8'h07;
    localparam logic [7:0] OP_DJNZ = 8'h08;
    localparam logic [7:0] OP_HLT  = 8'hFF;

    logic [7:0] r [4];
    logic [8:0] temp;
    logic       z_flag;
    logic       c_flag;

    logic [7:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic [7:0] rd_val;
    logic [7:0] rs_val;
    logic       act;
    logic       step0;
    logic       step1;

    assign opcode = ir[31:24];
    assign rd     = ir[17:16];
    assign rs     = ir[9:8];
    assign imm    = ir[7:0];
    assign rd_val = r[rd];
    assign rs_val = r[rs];

    // Reset forces the idle output values even while the core still presents EXEC_STATE.
    assign act   = (state == EXEC_STATE) && !reset;
    assign step0 = act && clks[0];
    assign step1 = act && clks[1] && !clks[0];

    assign jmp_address = ir[7:0];
    assign regs        = {r[3], r[2], r[1], r[0]};
    assign flags       = {c_flag, z_flag};

    always_comb begin
        end_inst       = 1'b0;
        jmp_inst       = 1'b0;
        hlt_inst       = 1'b0;
        inst_condition = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: end_inst = step1;
            OP_JMP: begin
                jmp_inst       = step0;
                inst_condition = step0;
                end_inst       = step0;
            end
            OP_JZ: begin
                jmp_inst       = step0;
                inst_condition = step0 && z_flag;
                end_inst       = step0;
            end
            OP_JC: begin
                jmp_inst       = step0;
                inst_condition = step0 && c_flag;
                end_inst       = step0;
            end
            // Rd already holds the decremented value by step 1.
            OP_DJNZ: begin
                jmp_inst       = step1;
                inst_condition = step1 && (rd_val != 8'h00);
                end_inst       = step1;
            end
            OP_HLT: begin
                hlt_inst = step0;
                end_inst = step0;
            end
            default: end_inst = step0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r[i] <= 8'h00;
            temp   <= 9'h000;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
        end else if (step0) begin
            case (opcode)
                OP_MOVI: r[rd] <= imm;
                OP_MOV:  r[rd] <= rs_val;
                OP_ADD:  temp  <= {1'b0, rd_val} + {1'b0, rs_val};
                // Bit 8 of the 9-bit difference is the borrow.
                OP_SUB:  temp  <= {1'b0, rd_val} - {1'b0, rs_val};
                OP_DJNZ: r[rd] <= rd_val - 8'h01;
                default: ;
            endcase
        end else if (step1) begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
                r[rd]  <= temp[7:0];
                c_flag <= temp[8];
                z_flag <= (temp[7:0] == 8'h00);
            end
        end
    end

    logic unused_nop;
    assign unused_nop = (opcode == OP_NOP);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-vector bench for cpu_control_unit with hand-computed register, flag and control expectations.
module tb_cpu_control_unit;

    localparam logic [1:0] EX   = 2'b01;
    localparam logic [1:0] IDLE = 2'b00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = 32'h0;
    logic [15:0] clks = 16'h0;
    logic [1:0]  state = IDLE;
    logic        inst_condition, end_inst, jmp_inst, hlt_inst;
    logic [7:0]  jmp_address;
    logic [31:0] regs;
    logic [1:0]  flags;

    int checks = 0;
    int failures = 0;

    cpu_control_unit #(.STEPS(16), .EXEC_STATE(EX)) dut (
        .clk(clk), .reset(reset), .ir(ir), .clks(clks), .state(state),
        .inst_condition(inst_condition), .end_inst(end_inst), .jmp_inst(jmp_inst),
        .hlt_inst(hlt_inst), .jmp_address(jmp_address), .regs(regs), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, 6'b0, rd, 6'b0, rs, imm};
    endfunction

    task automatic apply(input logic [31:0] i, input logic [15:0] c, input logic [1:0] s);
        ir = i; clks = c; state = s;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {jmp, cond, hlt, end}
    function automatic logic [31:0] ctl;
        return {28'h0, jmp_inst, inst_condition, hlt_inst, end_inst};
    endfunction

    task automatic run1(input logic [31:0] i);
        apply(i, 16'h0001, EX);
        tick;
    endtask

    task automatic run2(input logic [31:0] i);
        apply(i, 16'h0001, EX);
        tick;
        apply(i, 16'h0002, EX);
        tick;
    endtask

    initial begin
        #1;
        check("reset_regs", regs, 32'h0);
        check("reset_flags", {30'h0, flags}, 32'h0);
        check("reset_ctl", ctl(), 32'h0);
        tick;
        tick;
        reset = 1'b0;

        apply(ins(8'h01, 2, 0, 8'h5A), 16'h0001, EX);
        check("movi_end", ctl(), 32'h1);
        tick;
        check("movi_regs", regs, 32'h005A0000);
        check("movi_flags", {30'h0, flags}, 32'h0);

        run1(ins(8'h01, 0, 0, 8'hF0));
        run1(ins(8'h01, 1, 0, 8'h20));
        check("movi_r0_r1", regs, 32'h005A20F0);

        apply(ins(8'h03, 0, 1, 8'h00), 16'h0001, EX);
        check("add_s0_ctl", ctl(), 32'h0);
        tick;
        check("add_s0_nowrite", regs, 32'h005A20F0);
        apply(ins(8'h03, 0, 1, 8'h00), 16'h0002, EX);
        check("add_s1_ctl", ctl(), 32'h1);
        tick;
        check("add_regs", regs, 32'h005A2010);
        check("add_flags", {30'h0, flags}, 32'h2);

        run2(ins(8'h04, 0, 0, 8'h00));
        check("sub_self_regs", regs, 32'h005A2000);
        check("sub_self_flags", {30'h0, flags}, 32'h1);

        apply(ins(8'h06, 0, 0, 8'h3C), 16'h0001, EX);
        check("jz_taken_ctl", ctl(), 32'hD);
        check("jz_addr", {24'h0, jmp_address}, 32'h3C);
        tick;

        run2(ins(8'h03, 1, 1, 8'h00));
        check("add_double_regs", regs, 32'h005A4000);
        check("add_double_flags", {30'h0, flags}, 32'h0);
        apply(ins(8'h06, 0, 0, 8'h3C), 16'h0001, EX);
        check("jz_not_taken_ctl", ctl(), 32'h9);
        apply(ins(8'h07, 0, 0, 8'h3C), 16'h0001, EX);
        check("jc_not_taken_ctl", ctl(), 32'h9);
        apply(ins(8'h05, 0, 0, 8'hA7), 16'h0001, EX);
        check("jmp_ctl", ctl(), 32'hD);
        check("jmp_addr", {24'h0, jmp_address}, 32'hA7);
        tick;

        run1(ins(8'h01, 3, 0, 8'h02));
        apply(ins(8'h08, 3, 0, 8'h10), 16'h0001, EX);
        check("djnz1_s0_ctl", ctl(), 32'h0);
        tick;
        check("djnz1_regs", regs, 32'h015A4000);
        apply(ins(8'h08, 3, 0, 8'h10), 16'h0002, EX);
        check("djnz1_s1_ctl", ctl(), 32'hD);
        tick;
        check("djnz1_s1_nowrite", regs, 32'h015A4000);
        apply(ins(8'h08, 3, 0, 8'h10), 16'h0001, EX);
        tick;
        check("djnz2_regs", regs, 32'h005A4000);
        apply(ins(8'h08, 3, 0, 8'h10), 16'h0002, EX);
        check("djnz2_s1_ctl", ctl(), 32'h9);
        tick;
        apply(ins(8'h08, 3, 0, 8'h10), 16'h0001, EX);
        tick;
        check("djnz3_wrap_regs", regs, 32'hFF5A4000);
        apply(ins(8'h08, 3, 0, 8'h10), 16'h0002, EX);
        check("djnz3_s1_ctl", ctl(), 32'hD);
        tick;
        check("djnz_flags", {30'h0, flags}, 32'h0);

        apply(ins(8'hFF, 0, 0, 8'h00), 16'h0001, EX);
        check("hlt_ctl", ctl(), 32'h3);
        apply(ins(8'hFF, 0, 0, 8'h00), 16'h0001, IDLE);
        check("hlt_idle_ctl", ctl(), 32'h0);
        tick;
        check("hlt_idle_regs", regs, 32'hFF5A4000);

        apply(ins(8'h01, 0, 0, 8'hAA), 16'h0001, IDLE);
        check("movi_idle_ctl", ctl(), 32'h0);
        tick;
        check("movi_idle_regs", regs, 32'hFF5A4000);
        apply(ins(8'h01, 0, 0, 8'hAA), 16'h0004, EX);
        check("movi_late_step_ctl", ctl(), 32'h0);
        tick;
        check("movi_late_step_regs", regs, 32'hFF5A4000);
        apply(ins(8'hFF, 0, 0, 8'h00), 16'h0002, EX);
        check("hlt_late_step_ctl", ctl(), 32'h0);
        apply(ins(8'h01, 0, 0, 8'hAA), 16'h0000, EX);
        check("clks_zero_ctl", ctl(), 32'h0);
        tick;
        check("clks_zero_regs", regs, 32'hFF5A4000);

        apply(ins(8'h01, 1, 0, 8'h77), 16'h0003, EX);
        check("multihot_ctl", ctl(), 32'h1);
        tick;
        check("multihot_regs", regs, 32'hFF5A7700);
        apply(ins(8'h42, 1, 0, 8'h11), 16'h0001, EX);
        check("undef_ctl", ctl(), 32'h1);
        tick;
        check("undef_regs", regs, 32'hFF5A7700);

        apply(ins(8'h02, 3, 1, 8'h00), 16'h0001, EX);
        check("mov_ctl", ctl(), 32'h1);
        tick;
        check("mov_regs", regs, 32'h775A7700);

        run1(ins(8'h01, 0, 0, 8'h05));
        run1(ins(8'h01, 1, 0, 8'h03));
        check("pre_reset_regs", regs, 32'h775A0305);
        run1(ins(8'h03, 0, 1, 8'h00));
        apply(ins(8'h03, 0, 1, 8'h00), 16'h0002, EX);
        reset = 1'b1;
        #1;
        check("midreset_regs", regs, 32'h0);
        check("midreset_flags", {30'h0, flags}, 32'h0);
        check("midreset_ctl", ctl(), 32'h0);
        tick;
        reset = 1'b0;
        apply(ins(8'h03, 0, 1, 8'h00), 16'h0002, EX);
        check("postreset_s1_ctl", ctl(), 32'h1);
        tick;
        check("postreset_regs", regs, 32'h0);
        check("postreset_flags", {30'h0, flags}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
